tart_bank_reader: RTL and testbench
===================================

Name: tart_bank_reader

Overview:
Bus-domain consumer of the correlator bank-swap pulse. On each swap it reads back the just-completed correlator bank, word by word, from the visibilities block-RAM. It presents the words as a valid/ready stream to the bus/SPI readout path. It tracks the bank pointer, queues one pending bank and flags overruns when the host drains too slowly.

Parameters:
WIDTH, 24, accumulator word width in bits
WBITS, 6, log2 of words per bank (WORDS = 2**WBITS)
BBITS, 4, log2 of number of banks (bank pointer wraps modulo 2**BBITS)

Ports:
clk_i  in  1  bus clock; sole clock of the block
rst_ni  in  1  asynchronous active-low reset
en_i  in  1  readback enable; gates acceptance of swap_i
swap_i  in  1  one-cycle pulse (bus domain): a correlator bank has completed
mem_rd_o  out  1  block-RAM read strobe
mem_adr_o  out  BBITS+WBITS  read address {bank, index}
mem_dat_i  in  WIDTH  read data, valid the cycle after mem_rd_o
dat_o  out  WIDTH  stream data
valid_o  out  1  stream data valid
last_o  out  1  marks word WORDS-1 of a bank
ready_i  in  1  stream consumer ready
bank_o  out  BBITS  bank currently being read
busy_o  out  1  readout in progress
overflow_o  out  1  sticky overrun flag
clr_i  in  1  clears overflow_o

Behaviour:
- Reset: asynchronous and active-low; clk_i and rst_ni are the only clock/reset. Asserting rst_ni low clears everything immediately: FSM to IDLE, bank pointer 0, pending 0, FIFO empty, and all outputs 0 (valid_o included). Deassertion is synchronous to clk_i. Reset mid-readout abandons the bank; no last_o is emitted.
- Swap acceptance: swap_i counts only when en_i=1. While en_i=0, swaps are ignored and the pointer does not move. Dropping en_i mid-readout does not abort the current bank.
- Bank pointer: the first accepted swap reads bank 0. Each subsequent completed bank is pointer+1 mod 2**BBITS, so 2**BBITS-1 wraps to 0.
- FSM IDLE -> READ on an accepted swap; mem_rd_o first asserts the following cycle with index 0.
- FSM READ: issues a read (index++) whenever FIFO occupancy plus in-flight reads is less than 2. After index WORDS-1 is issued:
  - if pending=1: clear pending, advance the bank, go to READ with index 0 (back-to-back, no bubble);
  - otherwise go to DRAIN.
- FSM DRAIN -> IDLE when the FIFO is empty and no read is in flight.
- Latency with ready_i=1: swap sampled at edge 0 -> mem_rd_o in cycle 1 -> valid_o in cycle 3. Throughput is then one word per cycle.
- Output: 2-entry FIFO. Each word is written the cycle after its mem_rd_o. dat_o/valid_o come from the FIFO head. last_o = valid_o and head word index = WORDS-1. A word is consumed when valid_o and ready_i are both high. dat_o and last_o are held stable while valid_o=1 and ready_i=0.
- busy_o: high from the cycle after swap acceptance until the FSM returns to IDLE.
- Swap while busy with pending=0: set pending; the pending bank is pointer+1.
- Swap while busy with pending=1: set overflow_o and advance the pending bank by 1, skipping the older bank so the pointer stays aligned with the correlator's write bank.
- A swap arriving in the same cycle as the final read issue is treated as pending, giving a back-to-back start.
- overflow_o: sticky until clr_i. If clr_i and a new overflow occur in the same cycle, set wins.
- Arithmetic: the index counter is WBITS+1 bits wide to detect the end of a bank. Bank arithmetic is modulo 2**BBITS.

Decomposition:
- Shared package: FSM state encoding (IDLE, READ, DRAIN); the address-concatenation helper {bank, index}.
- Sub-module tart_skid_fifo2: a 2-entry valid/ready FIFO with async active-low reset.

Test Plan:
1. WBITS=2, en_i=1, ready_i=1; single swap at edge 0 -> mem_adr_o 0,1,2,3 in cycles 1-4; valid_o cycles 3-6; last_o in cycle 6 with the word from address 3; busy_o falls in cycle 7; bank_o=0.
2. 2**BBITS+1 swaps, each spaced after the previous bank completes -> banks read 0..15 then 0; bank_o wraps correctly; overflow_o=0.
3. ready_i toggled 1,0,0,1 during readout -> dat_o held stable while stalled; no word lost or duplicated; mem_rd_o throttled to FIFO space (never more than 2 words buffered or in flight).
4. Swap arrives mid-readout of bank 0 -> bank 1 starts with no idle cycle (mem_adr_o jumps from {0,3} to {1,0}); overflow_o=0.
5. Three swaps during one readout -> overflow_o=1; bank 1 skipped, bank 2 read next; clr_i then returns overflow_o to 0.
6. rst_ni pulled low mid-bank -> valid_o, busy_o, mem_rd_o go 0 without a clock edge; after release, the next swap reads bank 0 from index 0.

Source files
------------

// File: rtl/tart_bank_reader_pkg.sv
// ---------------------------------------------------------------------------
// tart_bank_reader_pkg
// Shared definitions for the correlator bank readback block:
//   state_e  - readback FSM encoding (IDLE, READ, DRAIN)
//   mk_adr   - builds the block-RAM read address {bank, index}
// ---------------------------------------------------------------------------
package tart_bank_reader_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_DRAIN = 2'd2
   } state_e;

   // Concatenates bank and word index; the caller casts the result down to
   // BBITS+WBITS bits.
   function automatic logic [31:0] mk_adr(input logic [31:0] bank,
                                          input logic [31:0] idx,
                                          input int unsigned wbits);
      return (bank << wbits) | idx;
   endfunction

endpackage

// File: rtl/tart_skid_fifo2.sv
// ---------------------------------------------------------------------------
// tart_skid_fifo2
// Two-entry valid/ready FIFO. The head is presented combinationally on
// o_data/o_valid; a word leaves when o_valid and i_ready are both high.
// Ports:
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_push, i_data   write strobe and word (dropped only if full and not popping)
//   i_ready          consumer ready
//   o_valid, o_data  head word (o_data forced to 0 while empty)
//   o_count          current occupancy 0..2
// ---------------------------------------------------------------------------
module tart_skid_fifo2
   import tart_bank_reader_pkg::*;
#(
   parameter int W = 25
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic         i_push,
   input  logic [W-1:0] i_data,
   input  logic         i_ready,
   output logic         o_valid,
   output logic [W-1:0] o_data,
   output logic [1:0]   o_count
);

   logic [W-1:0] r_mem [2];
   logic         r_wp;
   logic         r_rp;
   logic [1:0]   r_cnt;
   logic         w_push;
   logic         w_pop;

   assign o_valid = (r_cnt != 2'd0);
   assign w_pop   = o_valid & i_ready;
   // A full FIFO can still accept a word in the cycle its head leaves.
   assign w_push  = i_push & ((r_cnt != 2'd2) | w_pop);
   assign o_data  = o_valid ? r_mem[r_rp] : '0;
   assign o_count = r_cnt;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wp  <= 1'b0;
         r_rp  <= 1'b0;
         r_cnt <= 2'd0;
      end else begin
         if (w_push) r_wp <= ~r_wp;
         if (w_pop)  r_rp <= ~r_rp;
         case ({w_push, w_pop})
            2'b10:   r_cnt <= r_cnt + 2'd1;
            2'b01:   r_cnt <= r_cnt - 2'd1;
            default: r_cnt <= r_cnt;
         endcase
      end
   end

   // Storage is data only; emptiness is tracked by r_cnt.
   always_ff @(posedge i_clk) begin
      if (w_push) r_mem[r_wp] <= i_data;
   end

endmodule

// File: rtl/tart_bank_reader.sv
// ---------------------------------------------------------------------------
// tart_bank_reader
// Reads back each completed correlator bank from the visibilities block-RAM
// after a bank-swap pulse and streams the words out over valid/ready.
// One further bank can be queued while a readout is running; a swap beyond
// that raises a sticky overflow and skips the oldest queued bank.
// Ports:
//   clk_i, rst_ni          bus clock, asynchronous active-low reset
//   en_i, swap_i           readback enable, bank-complete pulse
//   mem_rd_o, mem_adr_o    block-RAM read strobe and {bank, index} address
//   mem_dat_i              read data, valid the cycle after mem_rd_o
//   dat_o, valid_o, last_o output stream; last_o marks word WORDS-1
//   ready_i                stream consumer ready
//   bank_o, busy_o         bank being read, readout in progress
//   overflow_o, clr_i      sticky overrun flag and its clear
// ---------------------------------------------------------------------------
module tart_bank_reader
   import tart_bank_reader_pkg::*;
#(
   parameter int WIDTH = 24,
   parameter int WBITS = 6,
   parameter int BBITS = 4
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   en_i,
   input  logic                   swap_i,
   output logic                   mem_rd_o,
   output logic [BBITS+WBITS-1:0] mem_adr_o,
   input  logic [WIDTH-1:0]       mem_dat_i,
   output logic [WIDTH-1:0]       dat_o,
   output logic                   valid_o,
   output logic                   last_o,
   input  logic                   ready_i,
   output logic [BBITS-1:0]       bank_o,
   output logic                   busy_o,
   output logic                   overflow_o,
   input  logic                   clr_i
);

   localparam int ADR_W = BBITS + WBITS;
   localparam logic [BBITS-1:0] BANK_ONE = BBITS'(1);
   localparam logic [WBITS:0]   IDX_ONE  = (WBITS+1)'(1);

   state_e           r_state;
   state_e           w_state_nxt;
   logic [BBITS-1:0] r_bank;       // bank being read
   logic [BBITS-1:0] w_bank_nxt;
   logic [BBITS-1:0] r_nxt;        // bank the next (or pending) readout uses
   logic [BBITS-1:0] w_nxt_nxt;
   logic [WBITS:0]   r_idx;        // extra bit flags the end of a bank
   logic [WBITS:0]   w_idx_nxt;
   logic [WBITS:0]   w_idx_inc;
   logic             r_pend;
   logic             w_pend_nxt;
   logic             r_ovf;
   logic             w_ovf_set;
   logic             r_infl;       // a read was issued last cycle
   logic             r_infl_last;  // ...and it was word WORDS-1
   logic             w_rd;
   logic             w_final;
   logic             w_swap;
   logic             w_pend_eff;
   logic [BBITS-1:0] w_nxt_eff;
   logic             w_pop;
   logic             w_room;
   logic             w_drained;
   logic             w_valid;
   logic [WIDTH:0]   w_head;
   logic [1:0]       w_cnt;

   tart_skid_fifo2 #(.W(WIDTH + 1)) u_fifo (
      .i_clk   (clk_i),
      .i_rst_n (rst_ni),
      .i_push  (r_infl),
      .i_data  ({r_infl_last, mem_dat_i}),
      .i_ready (ready_i),
      .o_valid (w_valid),
      .o_data  (w_head),
      .o_count (w_cnt)
   );

   assign w_swap    = swap_i & en_i;
   assign w_pop     = w_valid & ready_i;
   assign w_idx_inc = r_idx + IDX_ONE;
   // Occupancy after this cycle's pop plus the read in flight must stay
   // below 2 for a new read to fit; counting the pop keeps one word/cycle.
   assign w_room    = ({1'b0, w_cnt} + {2'b00, r_infl}) < (3'd2 + {2'b00, w_pop});
   assign w_drained = ({1'b0, w_cnt} == {2'b00, w_pop}) && !r_infl;

   // -- FSM state register ---------------------------------------------------
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state     <= ST_IDLE;
         r_bank      <= '0;
         r_nxt       <= '0;
         r_idx       <= '0;
         r_pend      <= 1'b0;
         r_ovf       <= 1'b0;
         r_infl      <= 1'b0;
         r_infl_last <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_bank      <= w_bank_nxt;
         r_nxt       <= w_nxt_nxt;
         r_idx       <= w_idx_nxt;
         r_pend      <= w_pend_nxt;
         r_infl      <= w_rd;
         r_infl_last <= w_rd & w_final;
         // A new overrun takes priority over a simultaneous clear.
         if (w_ovf_set)  r_ovf <= 1'b1;
         else if (clr_i) r_ovf <= 1'b0;
      end
   end

   // -- FSM next state and read issue ----------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      w_bank_nxt  = r_bank;
      w_nxt_nxt   = r_nxt;
      w_idx_nxt   = r_idx;
      w_pend_nxt  = r_pend;
      w_ovf_set   = 1'b0;
      w_rd        = 1'b0;
      w_final     = 1'b0;
      w_pend_eff  = r_pend;
      w_nxt_eff   = r_nxt;

      // Swap during a readout: queue it, or if a bank is already queued,
      // flag the overrun and move the queued bank on so the pointer keeps
      // tracking the correlator's write bank.
      if (w_swap && (r_state != ST_IDLE)) begin
         if (r_pend) begin
            w_ovf_set = 1'b1;
            w_nxt_eff = r_nxt + BANK_ONE;
         end else begin
            w_pend_eff = 1'b1;
         end
      end

      case (r_state)
         ST_IDLE: begin
            if (w_swap) begin
               w_state_nxt = ST_READ;
               w_idx_nxt   = '0;
               w_bank_nxt  = r_nxt;
               w_nxt_nxt   = r_nxt + BANK_ONE;
            end
         end

         ST_READ: begin
            w_rd       = w_room;
            w_pend_nxt = w_pend_eff;
            w_nxt_nxt  = w_nxt_eff;
            if (w_rd) begin
               w_idx_nxt = w_idx_inc;
               w_final   = w_idx_inc[WBITS];
            end
            if (w_final) begin
               if (w_pend_eff) begin
                  // Back-to-back start of the queued bank, no idle cycle.
                  w_bank_nxt = w_nxt_eff;
                  w_nxt_nxt  = w_nxt_eff + BANK_ONE;
                  w_pend_nxt = 1'b0;
                  w_idx_nxt  = '0;
               end else begin
                  w_state_nxt = ST_DRAIN;
               end
            end
         end

         ST_DRAIN: begin
            w_pend_nxt = w_pend_eff;
            w_nxt_nxt  = w_nxt_eff;
            if (w_pend_eff) begin
               // Start the queued bank rather than dropping it in IDLE.
               w_state_nxt = ST_READ;
               w_bank_nxt  = w_nxt_eff;
               w_nxt_nxt   = w_nxt_eff + BANK_ONE;
               w_pend_nxt  = 1'b0;
               w_idx_nxt   = '0;
            end else if (w_drained) begin
               w_state_nxt = ST_IDLE;
            end
         end

         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // -- outputs ----------------------------------------------------------------
   assign mem_rd_o   = w_rd;
   assign mem_adr_o  = w_rd ? ADR_W'(mk_adr(32'(r_bank), 32'(r_idx[WBITS-1:0]), WBITS)) : '0;
   assign dat_o      = w_head[WIDTH-1:0];
   assign last_o     = w_head[WIDTH];
   assign valid_o    = w_valid;
   assign bank_o     = r_bank;
   assign busy_o     = (r_state != ST_IDLE);
   assign overflow_o = r_ovf;

endmodule

// File: tb/tb_tart_bank_reader.sv
module tb_tart_bank_reader;

   localparam int WIDTH = 24;
   localparam int WBITS = 2;
   localparam int BBITS = 4;
   localparam int WORDS = 4;
   localparam int ADR_W = BBITS + WBITS;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             en_i = 1'b1;
   logic             swap_i = 1'b0;
   logic             mem_rd_o;
   logic [ADR_W-1:0] mem_adr_o;
   logic [WIDTH-1:0] mem_dat_i = '0;
   logic [WIDTH-1:0] dat_o;
   logic             valid_o;
   logic             last_o;
   logic             ready_i = 1'b1;
   logic [BBITS-1:0] bank_o;
   logic             busy_o;
   logic             overflow_o;
   logic             clr_i = 1'b0;

   int total = 0;
   int bad = 0;
   logic [WIDTH:0] sb[$];

   always #5 clk = ~clk;

   tart_bank_reader #(.WIDTH(WIDTH), .WBITS(WBITS), .BBITS(BBITS)) dut (
      .clk_i      (clk),
      .rst_ni     (rst_n),
      .en_i       (en_i),
      .swap_i     (swap_i),
      .mem_rd_o   (mem_rd_o),
      .mem_adr_o  (mem_adr_o),
      .mem_dat_i  (mem_dat_i),
      .dat_o      (dat_o),
      .valid_o    (valid_o),
      .last_o     (last_o),
      .ready_i    (ready_i),
      .bank_o     (bank_o),
      .busy_o     (busy_o),
      .overflow_o (overflow_o),
      .clr_i      (clr_i)
   );

   function automatic logic [WIDTH-1:0] memfn(input logic [ADR_W-1:0] a);
      return WIDTH'(32'h5A5A5A ^ (32'(a) * 32'h010301));
   endfunction

   // Block-RAM model: data one cycle after the read strobe.
   always @(posedge clk) if (mem_rd_o) mem_dat_i <= memfn(mem_adr_o);

   // Stream monitor: scoreboard pops, hold-while-stalled, buffering bound.
   logic             prev_stall = 1'b0;
   logic [WIDTH-1:0] prev_dat;
   logic             prev_last;
   int               outst = 0;
   int               max_outst = 0;
   logic [WIDTH:0]   exp_w;

   always @(negedge clk) begin
      if (!rst_n) begin
         prev_stall = 1'b0;
         outst = 0;
      end else begin
         if (prev_stall) begin
            total++;
            if (valid_o !== 1'b1 || dat_o !== prev_dat || last_o !== prev_last) begin
               bad++;
               $display("FAIL hold: valid=%b dat=%h last=%b required valid=1 dat=%h last=%b",
                        valid_o, dat_o, last_o, prev_dat, prev_last);
            end
         end
         prev_stall = valid_o && !ready_i;
         prev_dat   = dat_o;
         prev_last  = last_o;
         if (valid_o && ready_i) begin
            total++;
            if (sb.size() == 0) begin
               bad++;
               $display("FAIL stream_extra: got dat=%h last=%b required no word", dat_o, last_o);
            end else begin
               exp_w = sb.pop_front();
               if ({last_o, dat_o} !== exp_w) begin
                  bad++;
                  $display("FAIL stream_word: got dat=%h last=%b required dat=%h last=%b",
                           dat_o, last_o, exp_w[WIDTH-1:0], exp_w[WIDTH]);
               end
            end
         end
         outst = outst + (mem_rd_o ? 1 : 0) - ((valid_o && ready_i) ? 1 : 0);
         if (outst > max_outst) max_outst = outst;
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      rst_n = 1'b0; swap_i = 1'b0; clr_i = 1'b0; en_i = 1'b1; ready_i = 1'b1;
      repeat (2) tick();
      sb.delete();
      rst_n = 1'b1;
      max_outst = 0;
      tick();
   endtask

   task automatic push_bank(input int b);
      logic [ADR_W-1:0] a;
      for (int w = 0; w < WORDS; w++) begin
         a = ADR_W'(b * WORDS + w);
         sb.push_back({(w == WORDS - 1), memfn(a)});
      end
   endtask

   task automatic do_swap();
      swap_i = 1'b1;
      tick();
      swap_i = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      @(negedge clk);
      while (busy_o === 1'b1 && n < 300) begin
         @(negedge clk);
         n++;
      end
      total++;
      if (busy_o !== 1'b0) begin
         bad++;
         $display("FAIL %s_timeout: busy=%b required 0", name, busy_o);
      end
      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL %s_missing: words left=%0d required 0", name, sb.size());
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #1;
      total++;
      if ({valid_o, busy_o, mem_rd_o, overflow_o, last_o} !== 5'b0) begin
         bad++;
         $display("FAIL reset_outputs: valid/busy/rd/ovf/last=%b required 00000",
                  {valid_o, busy_o, mem_rd_o, overflow_o, last_o});
      end
      total++;
      if (bank_o !== '0 || dat_o !== '0 || mem_adr_o !== '0) begin
         bad++;
         $display("FAIL reset_values: bank=%0d dat=%h adr=%0d required 0 0 0", bank_o, dat_o, mem_adr_o);
      end
      apply_reset();
   endtask

   task automatic test_single();
      logic exp_rd, exp_v, exp_l, exp_b;
      apply_reset();
      push_bank(0);
      do_swap();   // sampled at edge 0, now in cycle 1
      for (int c = 1; c <= 7; c++) begin
         @(negedge clk);
         exp_rd = (c <= 4);
         exp_v  = (c >= 3 && c <= 6);
         exp_l  = (c == 6);
         exp_b  = (c <= 6);
         total++;
         if ({mem_rd_o, valid_o, last_o, busy_o} !== {exp_rd, exp_v, exp_l, exp_b}) begin
            bad++;
            $display("FAIL single_ctl c%0d: rd/valid/last/busy=%b required %b", c,
                     {mem_rd_o, valid_o, last_o, busy_o}, {exp_rd, exp_v, exp_l, exp_b});
         end
         if (c <= 4) begin
            total++;
            if (mem_adr_o !== ADR_W'(c - 1) || bank_o !== '0) begin
               bad++;
               $display("FAIL single_adr c%0d: adr=%0d bank=%0d required %0d 0", c, mem_adr_o, bank_o, c - 1);
            end
         end
         @(posedge clk);
         #1;
      end
      wait_idle("single");
   endtask

   task automatic test_wrap();
      apply_reset();
      for (int i = 0; i <= 16; i++) begin
         push_bank(i % 16);
         do_swap();
         @(negedge clk);
         total++;
         if (bank_o !== BBITS'(i % 16)) begin
            bad++;
            $display("FAIL wrap_bank swap%0d: bank=%0d required %0d", i, bank_o, i % 16);
         end
         wait_idle("wrap");
      end
      total++;
      if (overflow_o !== 1'b0) begin
         bad++;
         $display("FAIL wrap_ovf: overflow=%b required 0", overflow_o);
      end
   endtask

   task automatic test_stall();
      logic pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
      int k = 0;
      apply_reset();
      push_bank(0);
      do_swap();
      while (k < 60) begin
         @(negedge clk);
         if (!busy_o) break;
         @(posedge clk);
         #1;
         ready_i = pat[k % 4];
         k++;
      end
      ready_i = 1'b1;
      wait_idle("stall");
      total++;
      if (max_outst > 2 || max_outst < 1) begin
         bad++;
         $display("FAIL stall_buffered: max=%0d required 1..2", max_outst);
      end
   endtask

   task automatic test_back_to_back();
      int adrs[$];
      int cyc[$];
      apply_reset();
      push_bank(0);
      push_bank(1);
      do_swap();
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk);
         if (mem_rd_o) begin
            adrs.push_back(int'(mem_adr_o));
            cyc.push_back(c);
         end
         @(posedge clk);
         #1;
         swap_i = (c == 1);
      end
      swap_i = 1'b0;
      total++;
      if (adrs.size() != 8) begin
         bad++;
         $display("FAIL b2b_count: reads=%0d required 8", adrs.size());
      end
      for (int i = 0; i < adrs.size() && i < 8; i++) begin
         total++;
         if (adrs[i] != i || cyc[i] != i + 1) begin
            bad++;
            $display("FAIL b2b_read%0d: adr=%0d cycle=%0d required adr=%0d cycle=%0d",
                     i, adrs[i], cyc[i], i, i + 1);
         end
      end
      wait_idle("b2b");
      total++;
      if (overflow_o !== 1'b0) begin
         bad++;
         $display("FAIL b2b_ovf: overflow=%b required 0", overflow_o);
      end
   endtask

   task automatic test_overflow();
      apply_reset();
      push_bank(0);
      push_bank(2);
      do_swap();
      for (int c = 1; c <= 4; c++) begin
         @(posedge clk);
         #1;
         swap_i = (c == 1 || c == 2);
      end
      swap_i = 1'b0;
      wait_idle("ovf");
      total++;
      if (overflow_o !== 1'b1) begin
         bad++;
         $display("FAIL ovf_set: overflow=%b required 1", overflow_o);
      end
      clr_i = 1'b1;
      tick();
      clr_i = 1'b0;
      @(negedge clk);
      total++;
      if (overflow_o !== 1'b0) begin
         bad++;
         $display("FAIL ovf_clear: overflow=%b required 0", overflow_o);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset_mid();
      apply_reset();
      push_bank(0);
      do_swap();
      tick();
      tick();        // cycle 3: first word on the stream
      @(negedge clk);
      total++;
      if (valid_o !== 1'b1 || busy_o !== 1'b1) begin
         bad++;
         $display("FAIL rstmid_pre: valid=%b busy=%b required 1 1", valid_o, busy_o);
      end
      #2;
      rst_n = 1'b0;
      #1;
      total++;
      if ({valid_o, busy_o, mem_rd_o, last_o} !== 4'b0) begin
         bad++;
         $display("FAIL rstmid_async: valid/busy/rd/last=%b required 0000",
                  {valid_o, busy_o, mem_rd_o, last_o});
      end
      sb.delete();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      // Disabled swaps neither start a readout nor move the pointer.
      en_i = 1'b0;
      do_swap();
      tick();
      @(negedge clk);
      total++;
      if (busy_o !== 1'b0 || mem_rd_o !== 1'b0) begin
         bad++;
         $display("FAIL en_gate: busy=%b rd=%b required 0 0", busy_o, mem_rd_o);
      end
      @(posedge clk);
      #1;
      en_i = 1'b1;
      push_bank(0);
      do_swap();
      @(negedge clk);
      total++;
      if (mem_rd_o !== 1'b1 || mem_adr_o !== '0 || bank_o !== '0) begin
         bad++;
         $display("FAIL rstmid_restart: rd=%b adr=%0d bank=%0d required 1 0 0", mem_rd_o, mem_adr_o, bank_o);
      end
      wait_idle("rstmid");
   endtask

   initial begin
      test_reset();
      test_single();
      test_wrap();
      test_stall();
      test_back_to_back();
      test_overflow();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
